// File: rtl/fft_ctrl.sv
// Frame controller around an FFT core: fills the input RAM, starts the transform, then streams result bins.
// Optional dropped-sample counter enabled by defining FFT_CTRL_DROP_CNT_EN.
module fft_ctrl #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9,
  parameter int FFT_SIZE  = 512
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [BIT_WIDTH-1:0]   sample,
  output logic                   wr_en,
  output logic [N-1:0]           wr_addr,
  output logic [BIT_WIDTH-1:0]   wr_data,
  output logic                   fft_start,
  input  logic                   fft_done,
  output logic                   rd_en,
  output logic [N-1:0]           rd_addr,
  input  logic [2*BIT_WIDTH-1:0] rd_data,
  output logic                   bin_valid,
  output logic [2*BIT_WIDTH-1:0] bin_data,
  output logic [N-1:0]           bin_idx,
  output logic                   frame_last,
  output logic                   busy,
  output logic [7:0]             dropped
);

  typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} state_t;

  localparam logic [N-1:0] LAST_ADDR = N'(FFT_SIZE - 1);

  state_t                 state_q, state_d;
  logic [N-1:0]           cnt_q, cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [N-1:0]           wr_addr_q, wr_addr_d;
  logic [BIT_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                   start_q, start_d;
  logic                   pipe_q, pipe_d;
  logic [N-1:0]           bin_idx_q, bin_idx_d;
  logic                   rd_en_c;
  logic [N-1:0]           rd_addr_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start_d   = 1'b0;
    rd_en_c   = 1'b0;
    rd_addr_c = '0;
    case (state_q)
      FILL: begin
        if (sample_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = sample;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
      end
      // fft_start is registered so it lands the cycle after the last RAM write
      START: begin
        start_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (fft_done) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        rd_en_c   = 1'b1;
        rd_addr_c = cnt_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Read-data alignment stage: the RAM answers one cycle after rd_en
  always_comb begin
    pipe_d    = rd_en_c;
    bin_idx_d = rd_en_c ? rd_addr_c : bin_idx_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      pipe_q    <= 1'b0;
      bin_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      pipe_q    <= pipe_d;
      bin_idx_q <= bin_idx_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign fft_start  = start_q;
  assign rd_en      = rd_en_c;
  assign rd_addr    = rd_addr_c;
  assign bin_valid  = pipe_q;
  assign bin_data   = pipe_q ? rd_data : '0;
  assign bin_idx    = bin_idx_q;
  assign frame_last = pipe_q && (bin_idx_q == LAST_ADDR);
  assign busy       = (state_q != FILL);

`ifdef FFT_CTRL_DROP_CNT_EN
  logic [7:0] dropped_q, dropped_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    dropped_d = dropped_q;
    if (sample_valid && (state_q != FILL))
      dropped_d = sat_inc8(dropped_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dropped_q <= '0;
    else        dropped_q <= dropped_d;
  end

  assign dropped = dropped_q;
`else
  assign dropped = 8'd0;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed scoreboard bench for fft_ctrl: RAM write and bin streams are checked against queued expectations.
module tb_fft_ctrl;
  localparam int BW = 16;
  localparam int N  = 9;
  localparam int FS = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sample_valid = 1'b0;
  logic [BW-1:0] sample = '0;
  logic          wr_en;
  logic [N-1:0]  wr_addr;
  logic [BW-1:0] wr_data;
  logic          fft_start;
  logic          fft_done = 1'b0;
  logic          rd_en;
  logic [N-1:0]  rd_addr;
  logic [2*BW-1:0] rd_data = '0;
  logic          bin_valid;
  logic [2*BW-1:0] bin_data;
  logic [N-1:0]  bin_idx;
  logic          frame_last;
  logic          busy;
  logic [7:0]    dropped;

  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;
  int drops = 0;

  logic [N+BW-1:0] wr_q[$];
  logic [N+2*BW:0] bin_q[$];
  logic [N+BW-1:0] we;
  logic [N+2*BW:0] be;
  logic [15:0]     ra;

  fft_ctrl #(.BIT_WIDTH(BW), .N(N), .FFT_SIZE(FS)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fft_start(fft_start), .fft_done(fft_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .bin_valid(bin_valid), .bin_data(bin_data), .bin_idx(bin_idx), .frame_last(frame_last),
    .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  // Result RAM model: word at address a holds {a, ~a}
  always @(posedge clk) begin
    ra = 16'(rd_addr);
    rd_data <= rd_en ? {ra, ~ra} : 32'h0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_drop(input int n);
`ifdef FFT_CTRL_DROP_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"},      64'(wr_en),      64'(0));
    chk({tag, "_wr_addr"},    64'(wr_addr),    64'(0));
    chk({tag, "_wr_data"},    64'(wr_data),    64'(0));
    chk({tag, "_fft_start"},  64'(fft_start),  64'(0));
    chk({tag, "_rd_en"},      64'(rd_en),      64'(0));
    chk({tag, "_rd_addr"},    64'(rd_addr),    64'(0));
    chk({tag, "_bin_valid"},  64'(bin_valid),  64'(0));
    chk({tag, "_bin_data"},   64'(bin_data),   64'(0));
    chk({tag, "_bin_idx"},    64'(bin_idx),    64'(0));
    chk({tag, "_frame_last"}, 64'(frame_last), 64'(0));
    chk({tag, "_busy"},       64'(busy),       64'(0));
    chk({tag, "_dropped"},    64'(dropped),    64'(0));
  endtask

  // Output monitors sample on the falling edge
  always @(negedge clk) begin
    if (fft_start) start_cnt++;
    if (wr_en) begin
      vectors++;
      assert (wr_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_wr: observed addr %0h data %0h expected no write", wr_addr, wr_data);
      end
      if (wr_q.size() != 0) begin
        we = wr_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(we[N+BW-1:BW]));
        chk("wr_data", 64'(wr_data), 64'(we[BW-1:0]));
      end
    end
    if (bin_valid) begin
      vectors++;
      assert (bin_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_bin: observed idx %0d expected no bin", bin_idx);
      end
      if (bin_q.size() != 0) begin
        be = bin_q.pop_front();
        chk("bin_idx",    64'(bin_idx),    64'(be[N+2*BW-1:2*BW]));
        chk("bin_data",   64'(bin_data),   64'(be[2*BW-1:0]));
        chk("frame_last", 64'(frame_last), 64'(be[N+2*BW]));
      end
    end else begin
      chk("frame_last_idle", 64'(frame_last), 64'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Frame 1: samples 0..511 with a few idle gaps and a stray fft_done in FILL
    for (int k = 0; k < FS; k++) begin
      if (k % 97 == 5) begin
        sample_valid = 1'b0;
        fft_done = 1'b0;
        tick();
      end
      chk("fill_busy", 64'(busy), 64'(0));
      chk("fill_no_start", 64'(fft_start), 64'(0));
      sample_valid = 1'b1;
      sample = BW'(k);
      fft_done = (k == 200);
      wr_q.push_back({N'(k), BW'(k)});
      tick();
    end
    sample_valid = 1'b0;
    fft_done = 1'b0;
    chk("start_cycle_fft_start", 64'(fft_start), 64'(0));
    chk("start_cycle_busy", 64'(busy), 64'(1));
    chk("start_cnt_before", 64'(start_cnt), 64'(0));
    tick();
    chk("fft_start_pulse", 64'(fft_start), 64'(1));
    chk("wait_busy", 64'(busy), 64'(1));

    // WAIT: drop samples, then fft_done ten cycles after fft_start
    sample_valid = 1'b1;
    drops = 1;
    tick();
    chk("fft_start_once", 64'(fft_start), 64'(0));
    for (int i = 1; i < 10; i++) begin
      drops++;
      tick();
    end
    drops++;
    fft_done = 1'b1;
    for (int i = 0; i < FS; i++) begin
      ra = 16'(i);
      bin_q.push_back({(i == FS - 1), N'(i), ra, ~ra});
    end
    tick();
    fft_done = 1'b0;
    chk("dropped_wait", 64'(dropped), 64'(exp_drop(drops)));

    // DRAIN: keep dropping until 300 total, stray fft_done mid-drain
    for (int c = 0; c < FS; c++) begin
      chk("drain_rd_en", 64'(rd_en), 64'(1));
      chk("drain_rd_addr", 64'(rd_addr), 64'(c));
      chk("drain_busy", 64'(busy), 64'(1));
      sample_valid = (drops < 300);
      if (drops < 300) drops++;
      fft_done = (c == 50);
      tick();
    end
    fft_done = 1'b0;
    chk("post_drain_rd_en", 64'(rd_en), 64'(0));
    chk("post_drain_busy", 64'(busy), 64'(0));
    chk("final_bin_valid", 64'(bin_valid), 64'(1));
    chk("final_frame_last", 64'(frame_last), 64'(1));
    chk("dropped_sat", 64'(dropped), 64'(exp_drop(300)));
    chk("start_cnt_f1", 64'(start_cnt), 64'(1));

    // Frame 2 begins in the cycle the final bin issues
    for (int k = 0; k < FS; k++) begin
      sample_valid = 1'b1;
      sample = BW'(16'h8000 + k);
      wr_q.push_back({N'(k), BW'(16'h8000 + k)});
      tick();
    end
    sample_valid = 1'b0;
    tick();
    chk("f2_fft_start", 64'(fft_start), 64'(1));
    chk("dropped_hold", 64'(dropped), 64'(exp_drop(300)));
    repeat (3) tick();
    fft_done = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ra = 16'(i);
      bin_q.push_back({(i == FS - 1), N'(i), ra, ~ra});
    end
    tick();
    fft_done = 1'b0;
    for (int c = 0; c <= 100; c++) begin
      chk("f2_rd_addr", 64'(rd_addr), 64'(c));
      tick();
    end

    // Reset while bin 100 is on the output
    chk("pre_rst_bin_valid", 64'(bin_valid), 64'(1));
    chk("pre_rst_bin_idx", 64'(bin_idx), 64'(100));
    reset = 1'b0;
    #1;
    check_all_zero("rst_drain");
    #1;
    reset = 1'b1;
    tick();
    chk("start_cnt_f2", 64'(start_cnt), 64'(2));

    // Frame 3: 511 samples must not start the FFT
    for (int k = 0; k < FS - 1; k++) begin
      sample_valid = 1'b1;
      sample = BW'(3 * k);
      wr_q.push_back({N'(k), BW'(3 * k)});
      tick();
    end
    sample_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("f3_no_start", 64'(fft_start), 64'(0));
      chk("f3_not_busy", 64'(busy), 64'(0));
    end
    chk("f3_bin_idle", 64'(bin_valid), 64'(0));
    sample_valid = 1'b1;
    sample = 16'hBEEF;
    wr_q.push_back({N'(FS - 1), 16'hBEEF});
    tick();
    sample_valid = 1'b0;
    chk("f3_start_cycle", 64'(fft_start), 64'(0));
    chk("f3_busy", 64'(busy), 64'(1));
    tick();
    chk("f3_fft_start", 64'(fft_start), 64'(1));
    repeat (2) tick();

    chk("wr_q_empty", 64'(wr_q.size()), 64'(0));
    chk("bin_q_empty", 64'(bin_q.size()), 64'(0));
    chk("start_cnt_total", 64'(start_cnt), 64'(3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16: sample width; an FFT bin is 2*BIT_WIDTH wide as {real, imag}.
REQ-002 SHALL have parameter N, default 9: bin/sample address width.
REQ-003 SHALL have parameter FFT_SIZE, default 512: samples per frame, and SHALL be equal to 2**N.
REQ-004 SHALL have clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have sample_valid  input  1  one-cycle strobe for a new audio sample.
REQ-007 SHALL have sample  input  BIT_WIDTH  audio sample, valid with sample_valid.
REQ-008 SHALL have wr_en, wr_addr, wr_data  output  1/N/BIT_WIDTH  FFT input RAM write port.
REQ-009 SHALL have fft_start  output  1  one-cycle pulse that starts the FFT core.
REQ-010 SHALL have fft_done  input  1  one-cycle pulse from the FFT core when the transform is complete.
REQ-011 SHALL have rd_en, rd_addr  output  1/N  FFT result RAM read port.
REQ-012 SHALL have rd_data  input  2*BIT_WIDTH  result RAM data, valid one cycle after rd_en.
REQ-013 SHALL have bin_valid, bin_data, bin_idx, frame_last  output  1/2*BIT_WIDTH/N/1  bin stream to the frequency decoder.
REQ-014 SHALL have busy  output  1  high in any state except FILL.
REQ-015 SHALL have dropped  output  8  count of discarded samples.

Function
REQ-016 SHALL implement the states FILL, START, WAIT and DRAIN, plus a 1-bit drain pipeline flag.
REQ-017 In FILL, on sample_valid, SHALL register wr_en=1, wr_addr=cnt and wr_data=sample (one-cycle latency), then increment cnt.
REQ-018 In FILL, SHALL go to START when sample_valid is high and cnt==FFT_SIZE-1, and SHALL clear cnt to 0.
REQ-019 In START, SHALL drive fft_start=1 for exactly one cycle, then go to WAIT.
REQ-020 In WAIT, SHALL go to DRAIN with cnt=0 on fft_done; WAIT SHALL have no timeout.
REQ-021 SHALL ignore fft_done in every state except WAIT.
REQ-022 In DRAIN, SHALL drive rd_en=1 and rd_addr=cnt on every cycle and increment cnt, for exactly FFT_SIZE consecutive cycles.
REQ-023 SHALL drive bin_valid=1 one cycle after each rd_en, with bin_data=rd_data and bin_idx equal to the previous rd_addr.
REQ-024 SHALL assert frame_last together with bin_valid only when bin_idx==FFT_SIZE-1.
REQ-025 After the read at address FFT_SIZE-1, SHALL return to FILL on the next cycle; the final bin_valid SHALL issue in that first FILL cycle.
REQ-026 SHALL accept a sample arriving in that first FILL cycle at address 0.
REQ-027 SHALL discard any sample_valid seen in START, WAIT or DRAIN, with no write.
REQ-028 SHALL count each discarded sample in dropped, saturating at 255.
REQ-029 SHALL wrap cnt modulo 2**N; the FSM SHALL never observe cnt==FFT_SIZE.
REQ-030 SHALL keep wr_en, rd_en, fft_start and bin_valid low outside the cycles listed above.

Reset
REQ-031 On reset low, SHALL asynchronously enter FILL and set cnt=0 and the pipeline flag to 0.
REQ-032 On reset low, SHALL set every output to 0 (busy=0, dropped=0).
REQ-033 A reset asserted mid-frame (any state) SHALL abort the frame; no further fft_start or bin_valid SHALL occur until a new full frame is collected.
REQ-034 The dropped counter SHALL clear only on reset.

Configuration
REQ-035 With macro FFT_CTRL_DROP_CNT_EN defined, the dropped counter SHALL be implemented as REQ-027 and REQ-028 describe.
REQ-036 Without FFT_CTRL_DROP_CNT_EN, dropped SHALL be tied to 0, no counter logic SHALL exist, and samples SHALL still be discarded.

Verification
REQ-037 Reset, then 512 sample_valid pulses with sample=k: writes to addr 0..511 with data 0..511, one fft_start pulse one cycle after the write to addr 511, busy=1.
REQ-038 fft_done 10 cycles after fft_start, result RAM model returning {idx,~idx}: 512 contiguous bin_valid, bin_idx 0..511, data matching, frame_last only on idx 511, busy=0 in the cycle after the last rd_en.
REQ-039 300 sample_valid during WAIT/DRAIN: no writes; dropped=255 with FFT_CTRL_DROP_CNT_EN, 0 without it.
REQ-040 fft_done pulsed in FILL and in DRAIN: no state change, no extra fft_start, drain sequence unaffected.
REQ-041 Reset asserted in DRAIN at bin_idx 100: all outputs 0 immediately; next fft_start only after 512 new samples.
REQ-042 Sample in the cycle the final bin_valid issues: written at addr 0 and frame counted, with no sample lost.
